// File: rtl/tone_voice_scheduler.sv
// rtl/tone_voice_scheduler.sv - timed note command FIFO feeding a four-voice tone player
module tone_voice_scheduler #(
    parameter int TICK_DIV   = 25000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          flush,
    output logic [31:0]                   note_word,
    output logic                          note_we,
    output logic [3:0]                    voice_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSIGN,
        S_DROP,
        S_WRITE,
        S_FLUSH
    } state_e;

    state_e state_q, state_d;

    // Command FIFO
    logic [15:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, push, pop;
    logic [15:0]   head;

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign cmd_ready = ~reset & ~full;
    assign push      = cmd_valid & cmd_ready & ~flush;
    assign pop       = (state_q == S_ASSIGN) || (state_q == S_DROP);
    assign head      = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[(state_q == S_FLUSH) ? '0 : wr_ptr_q] <= cmd_data;
        end
    end

    // A push arriving in the FLUSH cycle itself survives the clear as the sole entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (state_q == S_FLUSH) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push ? AW'(1) : '0;
            count_q  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign fifo_count = count_q;

    // Free-running duration tick
    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
        end
    end

    // Voice state
    logic [6:0] note_q [4];
    logic [6:0] note_d [4];
    logic [8:0] dur_q  [4];
    logic [8:0] dur_d  [4];
    logic [3:0] active_q, active_d;
    logic       dirty_q, dirty_d;
    logic [1:0] sel_q, free_idx;
    logic       any_free, head_empty_dur;

    assign any_free       = ~&active_q;
    assign head_empty_dur = (count_q != '0) && (head[15:7] == 9'd0);

    always_comb begin
        free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!active_q[i]) free_idx = 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (head_empty_dur)                      state_d = S_DROP;
                else if ((count_q != '0) && any_free)    state_d = S_ASSIGN;
                else if (dirty_q)                        state_d = S_WRITE;
            end
            S_ASSIGN: state_d = S_WRITE;
            S_DROP:   state_d = S_IDLE;
            S_WRITE:  state_d = S_IDLE;
            S_FLUSH:  state_d = S_WRITE;
            default:  state_d = S_IDLE;
        endcase
        if (flush) state_d = S_FLUSH;
    end

    // The voice picked in ASSIGN was free, so the tick loop never touches it that cycle.
    always_comb begin
        note_d   = note_q;
        dur_d    = dur_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        if (state_q == S_WRITE) dirty_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (active_q[i] && tick) begin
                dur_d[i] = dur_q[i] - 9'd1;
                if (dur_q[i] == 9'd1) begin
                    note_d[i]   = 7'd0;
                    active_d[i] = 1'b0;
                    dirty_d     = 1'b1;
                end
            end
        end
        if (state_q == S_ASSIGN) begin
            note_d[sel_q]   = head[6:0];
            dur_d[sel_q]    = head[15:7];
            active_d[sel_q] = 1'b1;
        end
        if (state_q == S_FLUSH) begin
            for (int i = 0; i < 4; i++) begin
                note_d[i] = 7'd0;
                dur_d[i]  = 9'd0;
            end
            active_d = 4'd0;
            dirty_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= 2'd0;
            active_q <= 4'd0;
            dirty_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                note_q[i] <= 7'd0;
                dur_q[i]  <= 9'd0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= (state_q == S_IDLE) ? free_idx : sel_q;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
        end
    end

    assign note_word    = {1'b0, note_q[3], 1'b0, note_q[2], 1'b0, note_q[1], 1'b0, note_q[0]};
    assign note_we      = (state_q == S_WRITE);
    assign voice_active = active_q;

endmodule

// File: doc/tone_voice_scheduler.md
# tone_voice_scheduler

Sequences timed notes onto the four-voice tone generator. CPU-side logic pushes {duration, note} commands into a small FIFO. The scheduler allocates each command to a free voice and counts its duration in ticks. It drives the packed 32-bit note word plus a one-cycle write strobe into the tone player's `noteID`/`we` inputs, so software never tracks voice occupancy or timing.

## Interface
- `TICK_DIV`, 25000: clk cycles per duration tick (1 ms at 25 MHz); legal ≥ 2.
- `FIFO_DEPTH`, 8: command FIFO entries; power of two, ≥ 2.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cmd_data` in 16: {duration[15:7], note[6:0]}; duration is in ticks.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full; forced 0 while `reset` is high.
- `flush` in 1: synchronous silence-all and clear.
- `note_word` out 32: {1'b0,v3[6:0],1'b0,v2,1'b0,v1,1'b0,v0} to tone player `noteID`.
- `note_we` out 1: one-cycle write strobe to tone player `we`.
- `voice_active` out 4: per-voice busy mask.
- `fifo_count` out log2(FIFO_DEPTH)+1: entries held.

## Operation
- Push on `cmd_valid & cmd_ready`. Pop only in ASSIGN or DROP. Push and pop in the same cycle are both legal; count is unchanged.
- Tick generator: counter 0..TICK_DIV-1. `tick` is high for one cycle when the counter equals TICK_DIV-1, then wraps to 0. Runs freely; it is not affected by `flush`.
- Per-voice 9-bit down-counter. On `tick`, every active voice decrements. A voice whose counter goes 1→0 clears its note field, clears its `voice_active` bit, and sets `dirty`.
- FSM states:
  - IDLE:
    - `flush` → FLUSH.
    - Else, head has duration 0 → DROP.
    - Else, FIFO non-empty and any voice free → ASSIGN.
    - Else, `dirty` → WRITE.
    - Else stay in IDLE.
  - ASSIGN: pick the lowest-index free voice (free mask sampled in IDLE). Load its field with note and its counter with duration. Set the active bit, pop, → WRITE. The loaded voice does not decrement if `tick` coincides. Other voices expire normally in the same cycle.
  - DROP: pop, no voice change, → IDLE.
  - WRITE: `note_we`=1 for this cycle with `note_word` stable. Clears `dirty`; an expiry in the same cycle re-sets it (set wins). → IDLE.
  - FLUSH: clear FIFO, all fields, counters and active bits, → WRITE. A push coincident with `flush` is discarded.
- `flush` in any state preempts: next state is FLUSH.
- A note value of 0 is legal. It occupies a voice silently for its duration (timed rest).
- With no free voice, the head command waits. The FIFO keeps accepting until full.

## Timing
- Reset values:
  - `note_word`=0, `note_we`=0, `voice_active`=0, `fifo_count`=0, state IDLE, `dirty`=0, tick counter 0.
  - `cmd_ready` is 1 from the first cycle after reset deasserts.
- Command latency: push at edge E0 into an empty FIFO with a free voice → ASSIGN at E1 → `note_we` high and the new `note_word` valid in cycle E2–E3.
- Voice lifetime for duration D: frees on the D-th tick after assignment, which is between D-1 and D tick periods. Expiry reaches the outputs via WRITE within 2 cycles if the FSM is idle.
- The write strobe is never asserted in consecutive cycles. Each WRITE reflects all expiries up to the previous edge.
- Back-to-back commands: one assignment per 3 cycles (IDLE, ASSIGN, WRITE).

## Test plan
Bench uses TICK_DIV=4, FIFO_DEPTH=4.
- **Single note:** push {D=3, note=49} → `note_we` pulse 2 cycles later with `note_word`=0x00000031 and `voice_active`=0001. After the third tick, a pulse with `note_word`=0 and `voice_active`=0000.
- **Overcommit:** push 5 commands with D=2, notes 10..14 → voices 0..3 get 10..13 (`note_word`=0x0D0C0B0A). Note 14 waits, then lands in voice 0 after the first expiry.
- **Drop and rest:** push {D=0, note=20} then {D=2, note=0} → the first is popped with no `note_we`. The second sets `voice_active`=0001 with `note_word`=0.
- **Backpressure:** all voices busy, push 4 commands → `fifo_count`=4 and `cmd_ready`=0. A 5th `cmd_valid` is ignored. `cmd_ready` returns to 1 after the first pop.
- **Flush mid-play:** 3 voices active and 2 queued, assert `flush` with a simultaneous push → FIFO empties and `voice_active`=0000. One `note_we` pulse with `note_word`=0; the pushed command is never played.
- **Coincidence:** ASSIGN lands on a `tick` cycle while voice 1 expires → the new voice keeps its full D. Voice 1 clears, and a single WRITE shows both changes.
